// File: rtl/pipeline_sink.sv
// pipeline_sink -- terminal consumer for a chain of stall-capable stages.
//
// Accepts the inputs/in_valid/in_flush stream leaving the last pipeline
// stage, buffers accepted beats in a first-word-fall-through FIFO drained by
// a ready/valid read port, and drives out_stall back to that stage. It also
// keeps a saturating beat counter, a sticky overflow flag and an optional
// rotate-XOR checksum of every accepted beat.
//
// Build option:
//   PIPELINE_SINK_CHECKSUM_EN  defined   -> checksum register is built
//                              undefined -> checksum is tied to 32'h0
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 4)
//   SKID   entries kept free for in-flight beats once stall asserts
//   CNT_W  width of beat_count
//
// Ports:
//   clk, reset_n     clock (rising edge), asynchronous active-low reset
//   inputs, in_valid upstream beat
//   in_flush         upstream flush: empties the FIFO, discards this beat
//   out_stall        backpressure to the upstream stage (registered decode)
//   rd_data/rd_valid/rd_ready  FIFO read port, head word falls through
//   overflow         sticky, set when a beat is dropped on a full FIFO
//   beat_count       accepted beats, saturating
//   checksum         running checksum of accepted beats
module pipeline_sink #(
  parameter int DEPTH = 8,
  parameter int SKID  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      inputs,
  input  logic             in_valid,
  input  logic             in_flush,
  output logic             out_stall,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] beat_count,
  output logic [31:0]      checksum
);

  // DEPTH is a power of two, so AW-bit pointers wrap modulo DEPTH for free.
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - SKID);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Flush masks the read side, so a flush cycle can never pop.
  always_comb begin
    full     = (count == FULL_CNT);
    rd_valid = (count != '0) & ~in_flush;
    pop      = rd_valid & rd_ready;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    push     = in_valid & ~in_flush & (~full | pop);
    drop     = in_valid & ~in_flush & full & ~pop;
  end

  assign rd_data   = mem[rd_ptr];
  // Decoded from registered count only: no input reaches out_stall.
  assign out_stall = (count >= STALL_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (in_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is reset on purpose so that rd_data reads zero
  // out of reset; without that requirement it would be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= inputs;
    end
  end

  // Statistics survive a flush; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      beat_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (push && beat_count != '1) beat_count <= beat_count + 1'b1;
    end
  end

`ifdef PIPELINE_SINK_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Rotate left by one, then fold in the accepted word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else if (push) begin
      checksum_q <= {checksum_q[30:0], checksum_q[31]} ^ inputs;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_sink.sv
// Self-checking bench for pipeline_sink (DEPTH=8, SKID=2, CNT_W=16).
// A queue-based reference model tracks the FIFO contents and statistics;
// one compare process checks every DUT output against it on each falling
// edge, and directed scenarios pin literal values.
module tb_pipeline_sink;

  localparam int DEPTH = 8;
  localparam int SKID  = 2;
  localparam int CNT_W = 16;

`ifdef PIPELINE_SINK_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      inputs;
  logic             in_valid;
  logic             in_flush;
  logic             out_stall;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             overflow;
  logic [CNT_W-1:0] beat_count;
  logic [31:0]      checksum;

  pipeline_sink #(.DEPTH(DEPTH), .SKID(SKID), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .inputs     (inputs),
    .in_valid   (in_valid),
    .in_flush   (in_flush),
    .out_stall  (out_stall),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .overflow   (overflow),
    .beat_count (beat_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]      mq[$];
  bit               m_ovf = 1'b0;
  logic [CNT_W-1:0] m_bc  = '0;
  logic [31:0]      m_ck  = '0;

  always @(posedge clk or negedge reset_n) begin
    bit v, p, acc;
    if (!reset_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_bc  = '0;
      m_ck  = '0;
    end else begin
      v   = (mq.size() != 0) && !in_flush;
      p   = v && rd_ready;
      acc = 1'b0;
      if (in_flush) begin
        mq.delete();
      end else begin
        if (in_valid && mq.size() == DEPTH && !p) m_ovf = 1'b1;
        else if (in_valid) acc = 1'b1;
        if (p) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(inputs);
          if (m_bc != {CNT_W{1'b1}}) m_bc = m_bc + 1'b1;
          m_ck = {m_ck[30:0], m_ck[31]} ^ inputs;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit exp_v;
    if (check_en && reset_n) begin
      exp_v = (mq.size() != 0) && !in_flush;
      check("cmp_rd_valid", rd_valid, exp_v);
      if (exp_v) check("cmp_rd_data", rd_data, mq[0]);
      check("cmp_out_stall", out_stall, mq.size() >= DEPTH - SKID);
      check("cmp_overflow", overflow, m_ovf);
      check("cmp_beat_count", beat_count, m_bc);
      check("cmp_checksum", checksum, CK_EN ? m_ck : 32'h0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [31:0] d, input bit f, input bit r);
    in_valid = v;
    inputs   = d;
    in_flush = f;
    rd_ready = r;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_valid"}, rd_valid, 1'b0);
    check({tag, "_out_stall"}, out_stall, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_beat_count"}, beat_count, 0);
    check({tag, "_checksum"}, checksum, 32'h0);
    check({tag, "_rd_data"}, rd_data, 32'h0);
  endtask

  int          rdy_pct;
  logic [31:0] ck_snap;
  logic [31:0] exp_word;

  initial begin
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset_state("rst0");
    check_en = 1'b1;
    repeat (2) to_pos();
    reset_n = 1'b1;

    // Checksum scenario, then reset mid-stream with three beats held.
    set_in(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    to_pos();
    set_in(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    to_neg();
    check("ck_first", checksum, CK_EN ? 32'h0000_0001 : 32'h0);
    to_pos();
    set_in(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    to_neg();
    check("ck_second", checksum, CK_EN ? 32'h8000_0002 : 32'h0);
    to_pos();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    to_neg();
    check("pre_rst_beat_count", beat_count, 3);
    check("pre_rst_rd_valid", rd_valid, 1'b1);
    check("pre_rst_rd_data", rd_data, 32'h1);
    #1 reset_n = 1'b0;
    #1 check_reset_state("rst_mid");
    to_pos();
    to_pos();
    reset_n = 1'b1;

    // Fill and overflow: 0x1..0x9 with no reads.
    for (int i = 1; i <= 9; i++) begin
      set_in(1'b1, 32'(i), 1'b0, 1'b0);
      to_neg();
      if (i == 6) check("fill_stall_after5", out_stall, 1'b0);
      if (i == 7) check("fill_stall_after6", out_stall, 1'b1);
      to_pos();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    to_neg();
    check("fill_overflow", overflow, 1'b1);
    check("fill_beat_count", beat_count, 8);
    check("fill_head", rd_data, 32'h1);
    to_pos();

    // Drain for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b1);
      to_neg();
      check("drain_rd_valid", rd_valid, i < 8);
      if (i < 8) check("drain_rd_data", rd_data, 32'(i + 1));
      check("drain_out_stall", out_stall, (8 - i) >= 6);
      to_pos();
    end

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
      to_pos();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h20 + 32'(i), 1'b0, 1'b1);
      to_neg();
      check("fullpp_rd_data", rd_data, 32'h10 + 32'(i));
      check("fullpp_out_stall", out_stall, 1'b1);
      to_pos();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    to_neg();
    check("fullpp_beat_count", beat_count, 20);
    check("fullpp_overflow", overflow, 1'b1);
    check("fullpp_still_full", out_stall, 1'b1);
    to_pos();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b1);
      exp_word = (i < 4) ? 32'h14 + 32'(i) : 32'h20 + 32'(i - 4);
      to_neg();
      check("fullpp_order", rd_data, exp_word);
      to_pos();
    end

    // Flush with five beats held, a beat offered and a read requested.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
      to_pos();
    end
    set_in(1'b1, 32'h99, 1'b1, 1'b1);
    to_neg();
    check("flush_no_valid", rd_valid, 1'b0);
    ck_snap = CK_EN ? m_ck : 32'h0;
    to_pos();
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    to_neg();
    check("flush_rd_valid", rd_valid, 1'b0);
    check("flush_out_stall", out_stall, 1'b0);
    check("flush_beat_count", beat_count, 25);
    check("flush_overflow", overflow, 1'b1);
    check("flush_checksum", checksum, ck_snap);
    to_pos();

    // Randomized traffic with varying read pressure and one reset.
    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 3)
        0:       rdy_pct = 10;
        1:       rdy_pct = 50;
        default: rdy_pct = 90;
      endcase
      for (int c = 0; c < 200; c++) begin
        in_valid = ($urandom_range(0, 99) < 70);
        rd_ready = ($urandom_range(0, 99) < rdy_pct);
        in_flush = ($urandom_range(0, 99) < 2);
        inputs   = $urandom;
        to_pos();
      end
      if (seg == 6) begin
        reset_n = 1'b0;
        #1 check("rand_rst_rd_valid", rd_valid, 1'b0);
        check("rand_rst_beat_count", beat_count, 0);
        to_pos();
        to_pos();
        reset_n = 1'b1;
      end
    end

    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    to_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_sink.md
# pipeline_sink

Terminal consumer for a chain of stall-capable pipeline stages. It accepts the `inputs`/`in_valid`/`in_flush` stream leaving the last stage and generates the `out_stall` backpressure that stage reads as its stall input. Accepted beats are held in a FIFO and drained through a ready/valid read port. The block also keeps beat and overflow statistics, plus an optional running checksum.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥4.
- `SKID`, 2, entries reserved for in-flight beats after stall asserts; 1..DEPTH-1.
- `CNT_W`, 16, width of `beat_count`.

Ports:
- `clk`  input  1  single clock, rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `inputs`  input  32  data from the upstream stage.
- `in_valid`  input  1  `inputs` carries a beat this cycle.
- `in_flush`  input  1  upstream flush; clears the FIFO.
- `out_stall`  output  1  backpressure to the upstream stage.
- `rd_data`  output  32  FIFO head word.
- `rd_valid`  output  1  `rd_data` is valid.
- `rd_ready`  input  1  consumer accepts the head word.
- `overflow`  output  1  sticky; a beat was dropped.
- `beat_count`  output  CNT_W  accepted beats; saturates at all-ones.
- `checksum`  output  32  running checksum of accepted beats.

## Operation
- **Storage.** Circular buffer with read pointer, write pointer and `count` (0..DEPTH). Pointers wrap modulo DEPTH.
- **Pop.** `pop = rd_valid & rd_ready`.
- **Read side.** First-word-fall-through.
  - `rd_valid = (count != 0) & !in_flush`.
  - `rd_data = mem[rd_ptr]` (don't-care when `rd_valid` = 0).
- **Push.** `push = in_valid & !in_flush & (count < DEPTH | pop)`. A pop and a push in the same cycle while full are both legal.
- **Drop.** `in_valid & !in_flush & count == DEPTH & !pop` drops the beat. `overflow` is set to 1 and stays set until reset. Nothing is written to the FIFO and `beat_count` does not change.
- **Count update.** `count <= count + push - pop`.
- **Backpressure.** `out_stall = (count >= DEPTH - SKID)`. It is decoded only from registered `count`; it has no combinational path from any input.
- **Flush.** When `in_flush` = 1:
  - Pointers and `count` go to 0 at the next edge.
  - `rd_valid` is forced to 0, so no pop can occur.
  - Any beat on `inputs` in that cycle is discarded and is not counted as overflow.
  - `beat_count`, `overflow` and `checksum` are not cleared.
- **Statistics.** On each push, `beat_count` increments, saturating at 2^CNT_W-1.
- **Checksum.** On each push, `checksum <= {checksum[30:0], checksum[31]} ^ inputs`.
- **Reset.** No state machine beyond the FIFO counters. Reset dominates all other events.

## Timing
- **Reset values.** While `reset_n` = 0, all state is cleared asynchronously: pointers, `count`, `overflow`, `beat_count`, `checksum`. This gives:
  - `rd_valid` = 0, `out_stall` = 0, `overflow` = 0, `beat_count` = 0, `checksum` = 0.
  - `rd_data` = 0: memory resets to 0.
- **Reset mid-operation.** Asserting `reset_n` discards the FIFO contents immediately.
- **Push-to-read latency.** A beat pushed at edge N appears on `rd_data` with `rd_valid` = 1 in the cycle after edge N, when the FIFO was empty.
- **Stall latency.** `out_stall` changes in the cycle after the edge at which `count` crosses DEPTH-SKID. With an upstream stage that has a one-cycle stall reaction, SKID ≥ 2 guarantees no drops.
- **Empty boundary.** `pop` while empty cannot occur because `rd_valid` = 0. Push while empty does not bypass to `rd_data` in the same cycle.
- **Full boundary.** Push while full without a pop is a drop, as defined in Operation.

## Configuration
- Macro: `PIPELINE_SINK_CHECKSUM_EN`.
- **Defined:** the checksum register and its update logic are built; `checksum` behaves as described in Operation.
- **Undefined:** no checksum register exists and `checksum` is tied to 32'h0. All other behaviour is identical.

## Test plan
All scenarios use DEPTH=8, SKID=2.

1. **Reset.** Drive `reset_n` low mid-stream with `count`=3 -> `rd_valid`=0, `out_stall`=0, `overflow`=0, `beat_count`=0, `checksum`=0 immediately.
2. **Fill and overflow.** `rd_ready`=0; push 0x1..0x9 on consecutive cycles -> `out_stall`=1 from the cycle after the 6th push. Beats 7 and 8 are accepted, 0x9 is dropped. Result: `overflow`=1, `beat_count`=8.
3. **Drain.** After scenario 2, set `rd_ready`=1 for 10 cycles -> `rd_data` reads 0x1..0x8 in order. `rd_valid` falls after the 8th pop. `out_stall` falls once `count` < 6.
4. **Full with simultaneous push and pop.** FIFO full, `in_valid`=1 and `rd_ready`=1 for 4 cycles -> `count` stays 8, `overflow` unchanged, `beat_count` +4, FIFO order preserved.
5. **Flush.** `count`=5, assert `in_flush` with `in_valid`=1, `rd_ready`=1 -> no pop that cycle; next cycle `count`=0, `rd_valid`=0, `out_stall`=0. `beat_count` and `checksum` are unchanged.
6. **Checksum.** With `PIPELINE_SINK_CHECKSUM_EN` defined, after reset push 0x00000001 then 0x80000000 -> `checksum` = 0x00000001, then 0x80000002. With the macro undefined, `checksum` stays 0.
